traffic_lamp_monitor: RTL and testbench
=======================================

// Module: traffic_lamp_monitor
// PURPOSE
//   Lamp-side consumer of the 2-bit light codes (La, Lb) produced by the traffic controller FSM.
//   Decodes each code to one-hot lamp drives and checks the sequence for safety violations.
//   On any violation it latches a fault and forces both directions to flashing red until
//   cleared. Sits between the controller FSM and the physical lamp drivers.
// PARAMETERS
//   MIN_YELLOW  3  min consecutive cycles a direction must show Y before R (>=1)
//   FLASH_HALF  4  cycles per half-period of fault flashing red (>=1)
// PORTS
//   clk         in   1  system clock, rising edge
//   reset       in   1  asynchronous, active-low reset
//   La          in   2  direction A code: 0=R 1=Y 2=G 3=illegal
//   Lb          in   2  direction B code, same encoding
//   clr_fault   in   1  single-cycle request to leave fault mode
//   lamp_a      out  3  direction A lamps {red,yellow,green}, registered
//   lamp_b      out  3  direction B lamps {red,yellow,green}, registered
//   fault       out  1  high while in FLASH state
//   fault_code  out  4  sticky cause {short_yellow,bad_transition,conflict,illegal_code}
// BEHAVIOUR
// - Reset (async, reset=0): state=RUN; lamp_a=lamp_b=3'b100; fault=0; fault_code=0;
//   prev_a=prev_b=R; yel_cnt_a=yel_cnt_b=0; flash counter=0, flash phase=on.
// - States: RUN, FLASH. All checks evaluated on La/Lb sampled at each rising edge in RUN only.
// - Fault conditions (any number may fire in one cycle; all fired bits set together):
//   bit0 illegal_code: La==3 or Lb==3.
//   bit1 conflict: La!=R and Lb!=R.
//   bit2 bad_transition: a legal code changes to a different legal code other than R->G,
//        G->Y, Y->R (e.g. G->R, R->Y, Y->G). No change is always legal.
//   bit3 short_yellow: Y->R with yel_cnt < MIN_YELLOW for that direction.
// - yel_cnt per direction: increments (saturating at MIN_YELLOW) on each edge sampling Y,
//   clears on each edge sampling non-Y. prev_x updated to sampled code each RUN edge.
// - RUN, no fault: at the edge, lamp_x <= decode(code): R=100, Y=010, G=001. Latency 1 cycle.
// - RUN, fault detected at edge: state<=FLASH, fault<=1, fault_code<=fired bits, lamps<=100/100
//   at that same edge (faulting code never reaches lamps). Flash counter=0, phase=on.
// - FLASH: yellow/green always 0; both reds driven equal, on for FLASH_HALF cycles then off for
//   FLASH_HALF, repeating. La/Lb ignored except for clear; fault_code frozen.
// - clr_fault in FLASH: honoured only if La==R and Lb==R that edge -> state<=RUN, fault<=0,
//   fault_code<=0, lamps<=100/100, prev=R, yel_cnt=0. Otherwise ignored, flashing continues.
// - clr_fault in RUN: no effect.
// - Reset asserted mid-operation (either state): immediate return to reset values, no clock needed.
// - 2-bit code width fixed; counters sized by $clog2 of parameter+1.
// TESTING
// 1 Reset, La=G Lb=R held -> after one edge lamp_a=001 lamp_b=100, fault=0.
// 2 A: G, Y x3 cycles, R; then B: R->G -> lamps track inputs 1 cycle late, fault stays 0.
// 3 La=G Lb=G -> same edge fault=1, fault_code=0010, lamps 100/100; reds off after 4 cycles, on after 8.
// 4 A: G, Y x2, R (MIN_YELLOW=3) -> fault_code=1000; A: G->R directly -> fault_code=0100; La=3 -> 0001.
// 5 In FLASH, clr_fault with La=G -> ignored; then clr_fault with La=Lb=R -> next edge RUN,
//   fault=0, fault_code=0, lamps 100/100; subsequent R->G legal.
// 6 Assert reset mid-FLASH between clock edges -> outputs return to 100/100, fault=0 immediately.

Source files
------------

// File: rtl/traffic_lamp_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_lamp_monitor_if
//  Description : Bundle between the traffic controller FSM (master) and the
//                lamp-side monitor (slave).
//                  La, Lb      2-bit light codes, 0=R 1=Y 2=G 3=illegal
//                  clr_fault   single-cycle request to leave fault mode
//                  lamp_a/b    registered one-hot lamps {red,yellow,green}
//                  fault       high while the monitor is flashing red
//                  fault_code  sticky cause
//                              {short_yellow,bad_transition,conflict,illegal}
//  Revision    : 1.0  initial release
// ============================================================================
interface traffic_lamp_monitor_if;
    logic [1:0] La;
    logic [1:0] Lb;
    logic       clr_fault;
    logic [2:0] lamp_a;
    logic [2:0] lamp_b;
    logic       fault;
    logic [3:0] fault_code;

    // Controller side: produces codes and clear requests, observes status.
    modport master (
        output La,
        output Lb,
        output clr_fault,
        input  lamp_a,
        input  lamp_b,
        input  fault,
        input  fault_code
    );

    // Monitor side: consumes codes, drives lamps and status.
    modport slave (
        input  La,
        input  Lb,
        input  clr_fault,
        output lamp_a,
        output lamp_b,
        output fault,
        output fault_code
    );
endinterface
`default_nettype wire

// File: rtl/traffic_lamp_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_lamp_monitor
//  Description : Lamp-side consumer of the controller light codes. Decodes
//                each code to one-hot lamp drives (1-cycle latency) and
//                checks the sequence for safety violations. Any violation
//                latches a fault and forces both directions to flashing red
//                until a clear is accepted while both codes are red.
//  Ports       : clk    - system clock, rising edge
//                reset  - asynchronous, active-low reset
//                bus    - traffic_lamp_monitor_if.slave
//                         (La, Lb, clr_fault in; lamp_a, lamp_b, fault,
//                          fault_code out)
//  Parameters  : MIN_YELLOW - min consecutive Y cycles before R (>=1)
//                FLASH_HALF - cycles per half-period of fault flashing (>=1)
//  Revision    : 1.0  initial release
// ============================================================================
module traffic_lamp_monitor #(
    parameter int MIN_YELLOW = 3,
    parameter int FLASH_HALF = 4
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    traffic_lamp_monitor_if.slave      bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] C_CODE_R   = 2'd0;
    localparam logic [1:0] C_CODE_Y   = 2'd1;
    localparam logic [1:0] C_CODE_G   = 2'd2;
    localparam logic [1:0] C_CODE_X   = 2'd3;

    localparam logic [2:0] C_LAMP_R   = 3'b100;
    localparam logic [2:0] C_LAMP_Y   = 3'b010;
    localparam logic [2:0] C_LAMP_G   = 3'b001;

    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);

    localparam logic [YW-1:0] C_YEL_MAX  = YW'(MIN_YELLOW);
    localparam logic [FW-1:0] C_FLASH_LAST = FW'(FLASH_HALF - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLASH = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    function automatic logic [2:0] f_decode(input logic [1:0] code);
        logic [2:0] lamp;
        lamp = C_LAMP_R;
        case (code)
            C_CODE_Y: lamp = C_LAMP_Y;
            C_CODE_G: lamp = C_LAMP_G;
            default:  lamp = C_LAMP_R;
        endcase
        return lamp;
    endfunction

    // A step between two different legal codes must follow R->G->Y->R.
    // Holding a code is always fine; illegal codes are flagged elsewhere.
    function automatic logic f_bad_step(input logic [1:0] prev_code,
                                        input logic [1:0] code);
        logic bad;
        bad = 1'b0;
        if ((prev_code != C_CODE_X) && (code != C_CODE_X) && (prev_code != code)) begin
            bad = !(((prev_code == C_CODE_R) && (code == C_CODE_G)) ||
                    ((prev_code == C_CODE_G) && (code == C_CODE_Y)) ||
                    ((prev_code == C_CODE_Y) && (code == C_CODE_R)));
        end
        return bad;
    endfunction

    // Consecutive-yellow counter, saturating so it never wraps on long holds.
    function automatic logic [YW-1:0] f_yel_next(input logic [YW-1:0] cnt,
                                                 input logic [1:0]    code);
        logic [YW-1:0] nxt;
        nxt = '0;
        if (code == C_CODE_Y) begin
            nxt = (cnt == C_YEL_MAX) ? cnt : cnt + YW'(1);
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    state_t          r_state,      w_state;
    logic [2:0]      r_lamp_a,     w_lamp_a;
    logic [2:0]      r_lamp_b,     w_lamp_b;
    logic            r_fault,      w_fault;
    logic [3:0]      r_fault_code, w_fault_code;
    logic [1:0]      r_prev_a,     w_prev_a;
    logic [1:0]      r_prev_b,     w_prev_b;
    logic [YW-1:0]   r_yel_a,      w_yel_a;
    logic [YW-1:0]   r_yel_b,      w_yel_b;
    logic [FW-1:0]   r_flash_cnt,  w_flash_cnt;
    logic            r_flash_on,   w_flash_on;

    // ------------------------------------------------------------------------
    // Safety checks on the codes presented this cycle
    // ------------------------------------------------------------------------
    logic       w_illegal;
    logic       w_conflict;
    logic       w_bad_a;
    logic       w_bad_b;
    logic       w_short_a;
    logic       w_short_b;
    logic [3:0] w_fired;
    logic       w_clear_ok;

    assign w_illegal  = (bus.La == C_CODE_X) || (bus.Lb == C_CODE_X);
    // Any non-red code (including illegal) counts as showing a go signal.
    assign w_conflict = (bus.La != C_CODE_R) && (bus.Lb != C_CODE_R);
    assign w_bad_a    = f_bad_step(r_prev_a, bus.La);
    assign w_bad_b    = f_bad_step(r_prev_b, bus.Lb);
    // The yellow counter holds the number of Y samples before this edge.
    assign w_short_a  = (r_prev_a == C_CODE_Y) && (bus.La == C_CODE_R) &&
                        (r_yel_a < C_YEL_MAX);
    assign w_short_b  = (r_prev_b == C_CODE_Y) && (bus.Lb == C_CODE_R) &&
                        (r_yel_b < C_YEL_MAX);
    assign w_fired    = {w_short_a | w_short_b, w_bad_a | w_bad_b,
                         w_conflict, w_illegal};
    // Leaving fault mode is only safe when the controller shows all-red.
    assign w_clear_ok = bus.clr_fault && (bus.La == C_CODE_R) &&
                        (bus.Lb == C_CODE_R);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_RUN;
            r_lamp_a     <= C_LAMP_R;
            r_lamp_b     <= C_LAMP_R;
            r_fault      <= 1'b0;
            r_fault_code <= 4'b0000;
            r_prev_a     <= C_CODE_R;
            r_prev_b     <= C_CODE_R;
            r_yel_a      <= '0;
            r_yel_b      <= '0;
            r_flash_cnt  <= '0;
            r_flash_on   <= 1'b1;
        end else begin
            r_state      <= w_state;
            r_lamp_a     <= w_lamp_a;
            r_lamp_b     <= w_lamp_b;
            r_fault      <= w_fault;
            r_fault_code <= w_fault_code;
            r_prev_a     <= w_prev_a;
            r_prev_b     <= w_prev_b;
            r_yel_a      <= w_yel_a;
            r_yel_b      <= w_yel_b;
            r_flash_cnt  <= w_flash_cnt;
            r_flash_on   <= w_flash_on;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state      = r_state;
        w_lamp_a     = r_lamp_a;
        w_lamp_b     = r_lamp_b;
        w_fault      = r_fault;
        w_fault_code = r_fault_code;
        w_prev_a     = r_prev_a;
        w_prev_b     = r_prev_b;
        w_yel_a      = r_yel_a;
        w_yel_b      = r_yel_b;
        w_flash_cnt  = r_flash_cnt;
        w_flash_on   = r_flash_on;

        case (r_state)
            ST_RUN: begin
                w_prev_a = bus.La;
                w_prev_b = bus.Lb;
                w_yel_a  = f_yel_next(r_yel_a, bus.La);
                w_yel_b  = f_yel_next(r_yel_b, bus.Lb);
                if (|w_fired) begin
                    // The offending codes never reach the lamps.
                    w_state      = ST_FLASH;
                    w_fault      = 1'b1;
                    w_fault_code = w_fired;
                    w_lamp_a     = C_LAMP_R;
                    w_lamp_b     = C_LAMP_R;
                    w_flash_cnt  = '0;
                    w_flash_on   = 1'b1;
                end else begin
                    w_lamp_a = f_decode(bus.La);
                    w_lamp_b = f_decode(bus.Lb);
                end
            end

            ST_FLASH: begin
                if (w_clear_ok) begin
                    w_state      = ST_RUN;
                    w_fault      = 1'b0;
                    w_fault_code = 4'b0000;
                    w_lamp_a     = C_LAMP_R;
                    w_lamp_b     = C_LAMP_R;
                    w_prev_a     = C_CODE_R;
                    w_prev_b     = C_CODE_R;
                    w_yel_a      = '0;
                    w_yel_b      = '0;
                    w_flash_cnt  = '0;
                    w_flash_on   = 1'b1;
                end else begin
                    // Each phase lasts FLASH_HALF edges; the lamp register
                    // follows the phase that applies after this edge.
                    if (r_flash_cnt == C_FLASH_LAST) begin
                        w_flash_cnt = '0;
                        w_flash_on  = !r_flash_on;
                    end else begin
                        w_flash_cnt = r_flash_cnt + FW'(1);
                    end
                    w_lamp_a = {w_flash_on, 2'b00};
                    w_lamp_b = {w_flash_on, 2'b00};
                end
            end

            default: begin
                w_state = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.lamp_a     = r_lamp_a;
    assign bus.lamp_b     = r_lamp_b;
    assign bus.fault      = r_fault;
    assign bus.fault_code = r_fault_code;

endmodule
`default_nettype wire

// File: tb/tb_traffic_lamp_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_lamp_monitor
//  Description : Self-checking bench for traffic_lamp_monitor
//                (MIN_YELLOW=3, FLASH_HALF=4). Each vector drives La/Lb/
//                clr_fault, pushes the expected registered outputs onto a
//                scoreboard queue, and the result is popped and compared one
//                cycle later.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_traffic_lamp_monitor;

    localparam logic [1:0] R = 2'd0;
    localparam logic [1:0] Y = 2'd1;
    localparam logic [1:0] G = 2'd2;
    localparam logic [1:0] X = 2'd3;

    localparam logic [2:0] LR  = 3'b100;
    localparam logic [2:0] LY  = 3'b010;
    localparam logic [2:0] LG  = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    typedef struct packed {
        logic [1:0] la;
        logic [1:0] lb;
        logic       clr;
        logic [2:0] ea;
        logic [2:0] eb;
        logic       ef;
        logic [3:0] ec;
    } vec_t;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic       f;
        logic [3:0] c;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    exp_t sb[$];

    traffic_lamp_monitor_if bus();

    traffic_lamp_monitor #(
        .MIN_YELLOW (3),
        .FLASH_HALF (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic [1:0] la, input logic [1:0] lb,
                                input logic clr, input logic [2:0] ea,
                                input logic [2:0] eb, input logic ef,
                                input logic [3:0] ec);
        vec_t v;
        v.la = la; v.lb = lb; v.clr = clr;
        v.ea = ea; v.eb = eb; v.ef = ef; v.ec = ec;
        return v;
    endfunction

    // Drive one vector, record its expectation, and advance past the edge.
    task automatic drive(input vec_t v);
        exp_t e;
        bus.La        = v.la;
        bus.Lb        = v.lb;
        bus.clr_fault = v.clr;
        e.a = v.ea; e.b = v.eb; e.f = v.ef; e.c = v.ec;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.clr_fault = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        exp_t e;
        reset         = 1'b0;
        bus.La        = G;
        bus.Lb        = R;
        bus.clr_fault = 1'b0;
        #12;
        e.a = LR; e.b = LR; e.f = 1'b0; e.c = 4'b0000;
        sb.push_back(e);
        e = sb.pop_front();
        n_vec++;
        if ({bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code} !== {e.a, e.b, e.f, e.c}) begin
            n_err++;
            $display("FAIL reset_state: got a=%b b=%b f=%b c=%b want a=%b b=%b f=%b c=%b",
                     bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code, e.a, e.b, e.f, e.c);
        end
        reset = 1'b1;
        drive(mk(G, R, 1'b0, LG, LR, 1'b0, 4'b0000));
        e = sb.pop_front();
        n_vec++;
        if ({bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code} !== {e.a, e.b, e.f, e.c}) begin
            n_err++;
            $display("FAIL reset_first_edge: got a=%b b=%b f=%b c=%b want a=%b b=%b f=%b c=%b",
                     bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code, e.a, e.b, e.f, e.c);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_normal();
        vec_t t[$];
        exp_t e;
        t.push_back(mk(Y, R, 1'b0, LY, LR, 1'b0, 4'b0000));
        t.push_back(mk(Y, R, 1'b0, LY, LR, 1'b0, 4'b0000));
        t.push_back(mk(Y, R, 1'b0, LY, LR, 1'b0, 4'b0000));
        t.push_back(mk(R, R, 1'b0, LR, LR, 1'b0, 4'b0000));
        t.push_back(mk(R, G, 1'b0, LR, LG, 1'b0, 4'b0000));
        t.push_back(mk(R, Y, 1'b0, LR, LY, 1'b0, 4'b0000));
        t.push_back(mk(R, Y, 1'b0, LR, LY, 1'b0, 4'b0000));
        t.push_back(mk(R, Y, 1'b0, LR, LY, 1'b0, 4'b0000));
        t.push_back(mk(R, R, 1'b0, LR, LR, 1'b0, 4'b0000));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            n_vec++;
            if ({bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code} !== {e.a, e.b, e.f, e.c}) begin
                n_err++;
                $display("FAIL normal[%0d]: got a=%b b=%b f=%b c=%b want a=%b b=%b f=%b c=%b", i,
                         bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code, e.a, e.b, e.f, e.c);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_conflict_flash();
        vec_t t[$];
        exp_t e;
        t.push_back(mk(G, G, 1'b0, LR, LR, 1'b1, 4'b0010));
        // Reds on for edges 1..3 after the fault, off for 4..7, on at 8.
        for (int k = 1; k <= 8; k++) begin
            if (k >= 4 && k < 8)
                t.push_back(mk(G, G, 1'b0, OFF, OFF, 1'b1, 4'b0010));
            else
                t.push_back(mk(G, G, 1'b0, LR, LR, 1'b1, 4'b0010));
        end
        t.push_back(mk(R, R, 1'b1, LR, LR, 1'b0, 4'b0000));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            n_vec++;
            if ({bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code} !== {e.a, e.b, e.f, e.c}) begin
                n_err++;
                $display("FAIL conflict_flash[%0d]: got a=%b b=%b f=%b c=%b want a=%b b=%b f=%b c=%b", i,
                         bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code, e.a, e.b, e.f, e.c);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_fault_causes();
        vec_t t[$];
        exp_t e;
        t.push_back(mk(G, R, 1'b0, LG, LR, 1'b0, 4'b0000));
        t.push_back(mk(Y, R, 1'b0, LY, LR, 1'b0, 4'b0000));
        t.push_back(mk(Y, R, 1'b0, LY, LR, 1'b0, 4'b0000));
        t.push_back(mk(R, R, 1'b0, LR, LR, 1'b1, 4'b1000));
        t.push_back(mk(R, R, 1'b1, LR, LR, 1'b0, 4'b0000));
        t.push_back(mk(G, R, 1'b0, LG, LR, 1'b0, 4'b0000));
        t.push_back(mk(R, R, 1'b0, LR, LR, 1'b1, 4'b0100));
        t.push_back(mk(R, R, 1'b1, LR, LR, 1'b0, 4'b0000));
        t.push_back(mk(X, R, 1'b0, LR, LR, 1'b1, 4'b0001));
        t.push_back(mk(R, R, 1'b1, LR, LR, 1'b0, 4'b0000));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            n_vec++;
            if ({bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code} !== {e.a, e.b, e.f, e.c}) begin
                n_err++;
                $display("FAIL fault_causes[%0d]: got a=%b b=%b f=%b c=%b want a=%b b=%b f=%b c=%b", i,
                         bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code, e.a, e.b, e.f, e.c);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_multi_fault();
        vec_t t[$];
        exp_t e;
        t.push_back(mk(X, G, 1'b0, LR, LR, 1'b1, 4'b0011));
        t.push_back(mk(R, R, 1'b1, LR, LR, 1'b0, 4'b0000));
        t.push_back(mk(G, R, 1'b0, LG, LR, 1'b0, 4'b0000));
        t.push_back(mk(Y, R, 1'b0, LY, LR, 1'b0, 4'b0000));
        // A: short yellow; B: R->Y bad step, both in one edge.
        t.push_back(mk(R, Y, 1'b0, LR, LR, 1'b1, 4'b1100));
        t.push_back(mk(R, R, 1'b1, LR, LR, 1'b0, 4'b0000));
        t.push_back(mk(R, G, 1'b0, LR, LG, 1'b0, 4'b0000));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            n_vec++;
            if ({bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code} !== {e.a, e.b, e.f, e.c}) begin
                n_err++;
                $display("FAIL multi_fault[%0d]: got a=%b b=%b f=%b c=%b want a=%b b=%b f=%b c=%b", i,
                         bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code, e.a, e.b, e.f, e.c);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_clear();
        vec_t t[$];
        exp_t e;
        // B is green from the previous test; bring it back to red legally.
        t.push_back(mk(R, Y, 1'b0, LR, LY, 1'b0, 4'b0000));
        t.push_back(mk(R, Y, 1'b0, LR, LY, 1'b0, 4'b0000));
        t.push_back(mk(R, Y, 1'b0, LR, LY, 1'b0, 4'b0000));
        t.push_back(mk(R, R, 1'b0, LR, LR, 1'b0, 4'b0000));
        t.push_back(mk(G, G, 1'b0, LR, LR, 1'b1, 4'b0010));
        t.push_back(mk(G, R, 1'b1, LR, LR, 1'b1, 4'b0010));
        t.push_back(mk(R, R, 1'b1, LR, LR, 1'b0, 4'b0000));
        t.push_back(mk(G, R, 1'b0, LG, LR, 1'b0, 4'b0000));
        t.push_back(mk(G, R, 1'b1, LG, LR, 1'b0, 4'b0000));
        t.push_back(mk(G, G, 1'b0, LR, LR, 1'b1, 4'b0010));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            n_vec++;
            if ({bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code} !== {e.a, e.b, e.f, e.c}) begin
                n_err++;
                $display("FAIL clear[%0d]: got a=%b b=%b f=%b c=%b want a=%b b=%b f=%b c=%b", i,
                         bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code, e.a, e.b, e.f, e.c);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_flash();
        vec_t t[$];
        exp_t e;
        // Still flashing from the previous test: on for 3 more edges, then off.
        t.push_back(mk(G, G, 1'b0, LR,  LR,  1'b1, 4'b0010));
        t.push_back(mk(G, G, 1'b0, LR,  LR,  1'b1, 4'b0010));
        t.push_back(mk(G, G, 1'b0, LR,  LR,  1'b1, 4'b0010));
        t.push_back(mk(G, G, 1'b0, OFF, OFF, 1'b1, 4'b0010));
        t.push_back(mk(G, G, 1'b0, OFF, OFF, 1'b1, 4'b0010));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            n_vec++;
            if ({bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code} !== {e.a, e.b, e.f, e.c}) begin
                n_err++;
                $display("FAIL reset_mid[%0d]: got a=%b b=%b f=%b c=%b want a=%b b=%b f=%b c=%b", i,
                         bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code, e.a, e.b, e.f, e.c);
            end
        end
        // Assert reset between edges; outputs must recover with no clock.
        reset = 1'b0;
        #2;
        e.a = LR; e.b = LR; e.f = 1'b0; e.c = 4'b0000;
        sb.push_back(e);
        e = sb.pop_front();
        n_vec++;
        if ({bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code} !== {e.a, e.b, e.f, e.c}) begin
            n_err++;
            $display("FAIL reset_async: got a=%b b=%b f=%b c=%b want a=%b b=%b f=%b c=%b",
                     bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code, e.a, e.b, e.f, e.c);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(mk(R, G, 1'b0, LR, LG, 1'b0, 4'b0000));
        e = sb.pop_front();
        n_vec++;
        if ({bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code} !== {e.a, e.b, e.f, e.c}) begin
            n_err++;
            $display("FAIL reset_resume: got a=%b b=%b f=%b c=%b want a=%b b=%b f=%b c=%b",
                     bus.lamp_a, bus.lamp_b, bus.fault, bus.fault_code, e.a, e.b, e.f, e.c);
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_normal();
        test_conflict_flash();
        test_fault_causes();
        test_multi_fault();
        test_clear();
        test_reset_mid_flash();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
